// File: rtl/rambam_pkg.sv
// rambam_pkg: shared constants and types for the RAMBAM S-box stages.
// Field and redundancy configuration come from the global macros `D, `P and `Q.
// The defaults are d=4, P=9'h11B (AES field) and Q=5'h13.
`ifndef D
`define D 4
`endif
`ifndef P
`define P 9'h11B
`endif
`ifndef Q
`define Q 5'h13
`endif

package rambam_pkg;

  localparam int unsigned d = `D;
  localparam logic [8:0]  P = 9'(`P);
  localparam logic [d:0]  Q = (d+1)'(`Q);

  // Carry-less product P(x)*Q(x): the modulus of the redundant domain.
  function automatic logic [8+d:0] poly_mul_pq();
    logic [8+d:0] r;
    r = '0;
    for (int unsigned i = 0; i < 9; i++)
      if (P[i]) r = r ^ ((9+d)'(Q) << i);
    return r;
  endfunction

  localparam logic [8+d:0] PQ = poly_mul_pq();

  localparam int unsigned  LFSR_W     = 64;
  localparam logic [63:0]  LFSR_TAPS  = 64'hB000_0000_0000_0001;
  localparam logic [63:0]  LFSR_RESET = 64'h1;

  // The last multiplier step handles the x^8 coefficient.
  localparam logic [3:0]   MUL_LAST   = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} enc_state_t;

  typedef logic [0:7+d] rambam_word_t;

endpackage

// File: rtl/rambam_lfsr.sv
// rambam_lfsr: 64-bit Galois LFSR, polynomial x^64+x^63+x^61+x^60+1.
// Used as a mask source for trace collection, not as a certified RNG.
// A load takes priority over a step, and an all-zero seed is replaced by the reset value.
module rambam_lfsr
  import rambam_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // Seed load, or multiply the state by x modulo the feedback polynomial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= LFSR_RESET;
    else if (load)
      state <= (seed == '0) ? LFSR_RESET : seed;
    else if (step)
      state <= {state[LFSR_W-2:0], 1'b0} ^ (state[LFSR_W-1] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/rambam_encoder.sv
// rambam_encoder: computes enc = a*Q ^ r0*P (unreduced, 8+d bits) and returns it
// together with seven fresh d-bit masks for the S-box.
// Both products are computed with shift-and-add, one coefficient per cycle.
// Optional feature macro: RAMBAM_ZERO_RAND_EN adds the zero_rand input.
module rambam_encoder
  import rambam_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:7]     in_byte,
  input  logic           seed_load,
  input  logic [63:0]    seed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:7+d]   out_enc,
  output logic [0:7*d-1] out_r
`ifdef RAMBAM_ZERO_RAND_EN
  ,
  input  logic           zero_rand
`endif
);

  if (d < 1 || d > 8) begin : g_bad_d
    $error("rambam_encoder: d must be in 1..8");
  end

  enc_state_t        state, state_next;
  logic [7:0]        a_reg;
  logic [d-1:0]      r0;
  logic [7*d-1:0]    r_snap;
  logic [7+d:0]      acc_p, acc_q, term_p, term_q, a_ext, r0_ext;
  logic [3:0]        cnt;
  logic [8*d-1:0]    snap_next;
  logic [8:0]        p_vec, q_ext;
  logic              zero_snap, lfsr_load;
  logic [LFSR_W-1:0] lfsr_state;
  logic              unused_lfsr_bits;
  rambam_word_t      enc_sum;

`ifdef RAMBAM_ZERO_RAND_EN
  assign zero_snap = zero_rand;
`else
  assign zero_snap = 1'b0;
`endif

  // Seeds are accepted only while idle, and an offered byte takes priority over the seed.
  assign lfsr_load = seed_load && !in_valid && (state == IDLE);

  rambam_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (1'b1),
    .load  (lfsr_load),
    .seed  (seed),
    .state (lfsr_state)
  );

  // The top 8d LFSR bits form the snapshot: r0 first, then r[0..6].
  assign snap_next        = zero_snap ? '0 : lfsr_state[LFSR_W-1 -: 8*d];
  assign unused_lfsr_bits = ^lfsr_state;

  assign p_vec  = P;
  assign q_ext  = 9'(Q);
  assign a_ext  = (8+d)'(a_reg);
  assign r0_ext = (8+d)'(r0);

  // Partial products for the polynomial coefficient selected by cnt.
  always_comb begin
    term_p = '0;
    term_q = '0;
    if (p_vec[cnt])
      term_p = r0_ext << cnt;
    if (32'(cnt) <= d && q_ext[cnt])
      term_q = a_ext << cnt;
  end

  // The final step's terms are folded in here so the result is registered on the same edge.
  assign enc_sum = acc_p ^ term_p ^ acc_q ^ term_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)          state_next = MUL;
      MUL:     if (cnt == MUL_LAST)   state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Handshake outputs depend only on the registered state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, accumulation and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      r0      <= '0;
      r_snap  <= '0;
      acc_p   <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      out_enc <= '0;
      out_r   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg  <= in_byte;
          r0     <= snap_next[8*d-1 -: d];
          r_snap <= snap_next[7*d-1:0];
          acc_p  <= '0;
          acc_q  <= '0;
          cnt    <= '0;
        end
        MUL: begin
          acc_p <= acc_p ^ term_p;
          acc_q <= acc_q ^ term_q;
          if (cnt == MUL_LAST) begin
            out_enc <= enc_sum;
            out_r   <= r_snap;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rambam_encoder.sv
// tb_rambam_encoder: directed checks of rambam_encoder for d=4, P=9'h11B, Q=5'h13.
// The hand-computed zero-randomness constants are checked when RAMBAM_ZERO_RAND_EN is defined.
`timescale 1ns/1ps
module tb_rambam_encoder;

  localparam int unsigned D       = 4;
  localparam logic [8:0]  P_TB    = 9'h11B;
  localparam logic [8:0]  Q_TB    = 9'h013;
  localparam logic [63:0] TAPS_TB = 64'hB000_0000_0000_0001;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           seed_load = 1'b0;
  logic           out_ready = 1'b0;
  logic [0:7]     in_byte   = '0;
  logic [63:0]    seed      = '0;
  logic           in_ready, out_valid;
  logic [0:7+D]   out_enc;
  logic [0:7*D-1] out_r;
`ifdef RAMBAM_ZERO_RAND_EN
  logic           zero_rand = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_lfsr;
  logic        m_idle   = 1'b1;
  logic [7:0]  q_inv;

  rambam_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .seed_load (seed_load),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_enc   (out_enc),
    .out_r     (out_r)
`ifdef RAMBAM_ZERO_RAND_EN
    ,
    .zero_rand (zero_rand)
`endif
  );

  always #5 clk = ~clk;

  // Reference mask generator: multiply by x modulo x^64+x^63+x^61+x^60+1.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [64:0] w;
    w = {s, 1'b0};
    if (w[64]) w[63:0] = w[63:0] ^ TAPS_TB;
    return w[63:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      m_lfsr <= 64'h1;
    else if (seed_load && !in_valid && m_idle)
      m_lfsr <= (seed == 64'h0) ? 64'h1 : seed;
    else
      m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [15:0] clmul(input logic [7:0] x, input logic [8:0] y);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 9; i++)
      if (y[i]) r = r ^ (16'(x) << i);
    return r;
  endfunction

  function automatic logic [7:0] gf_mod(input logic [15:0] v);
    for (int i = 15; i >= 8; i--)
      if (v[i]) v = v ^ (16'(P_TB) << (i - 8));
    return v[7:0];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    return gf_mod(clmul(x, {1'b0, y}));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: offer a byte, wait for the result, optionally stall, then handshake.
  task automatic send(input logic [7:0] a, input logic zr, input int unsigned hold,
                      input logic sl_mul, output logic [11:0] enc, output logic [27:0] r);
    logic [63:0] snap;
    logic [11:0] exp_enc;
    logic [27:0] exp_r;
    logic        zr_eff;
    int unsigned lat;
`ifdef RAMBAM_ZERO_RAND_EN
    zr_eff    = zr;
    zero_rand = zr;
`else
    zr_eff    = 1'b0;
`endif
    check("in_ready_idle", 64'(in_ready), 64'h1);
    in_valid = 1'b1;
    in_byte  = a;
    snap     = zr_eff ? 64'h0 : m_lfsr;
    tick();
    in_valid  = 1'b0;
    m_idle    = 1'b0;
    seed_load = 1'b0;
    if (sl_mul) begin
      seed_load = 1'b1;
      seed      = 64'h0123_4567_89AB_CDEF;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      if (lat == 3) seed_load = 1'b0;
      if (lat == 4) check("in_ready_busy", 64'(in_ready), 64'h0);
    end
    check("latency", 64'(lat), 64'd9);
    exp_enc = 12'(clmul(a, Q_TB) ^ clmul({4'h0, snap[63:60]}, P_TB));
    exp_r   = snap[59:32];
    enc     = out_enc;
    r       = out_r;
    check("enc", 64'(enc), 64'(exp_enc));
    check("r", 64'(r), 64'(exp_r));
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'h1);
      check("hold_ready", 64'(in_ready), 64'h0);
      check("hold_enc", 64'(out_enc), 64'(enc));
      check("hold_r", 64'(out_r), 64'(r));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_idle    = 1'b1;
    check("valid_drop", 64'(out_valid), 64'h0);
    check("ready_back", 64'(in_ready), 64'h1);
    if (hold > 0) begin
      tick();
      check("single_handshake", 64'(out_valid), 64'h0);
    end
  endtask

  initial begin
    logic [11:0] enc;
    logic [27:0] r;
    q_inv = 8'h00;
    for (int x = 1; x < 256; x++)
      if (gf_mul(8'(x), Q_TB[7:0]) == 8'h01) q_inv = 8'(x);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_enc", 64'(out_enc), 64'h0);
    check("rst_out_r", 64'(out_r), 64'h0);
    rst_n = 1'b1;
    tick();

    // Zero-randomness vectors
    send(8'h01, 1'b1, 0, 1'b0, enc, r);
`ifdef RAMBAM_ZERO_RAND_EN
    check("t1_enc_const", 64'(enc), 64'h013);
    check("t1_r_zero", 64'(r), 64'h0);
`endif
    send(8'h02, 1'b1, 0, 1'b0, enc, r);
`ifdef RAMBAM_ZERO_RAND_EN
    check("t2_enc_02", 64'(enc), 64'h026);
`endif
    send(8'hFF, 1'b1, 0, 1'b0, enc, r);
`ifdef RAMBAM_ZERO_RAND_EN
    check("t2_enc_ff", 64'(enc), 64'hEF1);
`endif

    // Seeded sweep of all byte values with live randomness
    seed      = 64'hDEAD_BEEF_0123_4567;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int b = 0; b < 256; b++) begin
      send(8'(b), 1'b0, 0, 1'b0, enc, r);
      check("t3_decode", 64'(gf_mul(gf_mod({4'h0, enc}), q_inv)), 64'(b));
    end

    // Consumer stall in DONE
    send(8'h5A, 1'b0, 5, 1'b0, enc, r);

    // Asynchronous reset in the middle of the multiply
    in_valid = 1'b1;
    in_byte  = 8'hC3;
    tick();
    in_valid = 1'b0;
    m_idle   = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("t5_valid_async", 64'(out_valid), 64'h0);
    check("t5_enc_async", 64'(out_enc), 64'h0);
    check("t5_r_async", 64'(out_r), 64'h0);
    m_idle = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_ready_after", 64'(in_ready), 64'h1);
    check("t5_valid_after", 64'(out_valid), 64'h0);
    send(8'h11, 1'b0, 0, 1'b0, enc, r);

    // Seed handling: zero seed, seed during multiply, seed coincident with a byte
    seed      = 64'h0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    send(8'h37, 1'b0, 0, 1'b0, enc, r);
    send(8'h9C, 1'b0, 0, 1'b1, enc, r);
    send(8'hE4, 1'b0, 0, 1'b0, enc, r);
    seed      = 64'hFFFF_0000_FFFF_0000;
    seed_load = 1'b1;
    send(8'h42, 1'b0, 0, 1'b0, enc, r);
    send(8'hA7, 1'b0, 0, 1'b0, enc, r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
